// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one step per cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, div0, last, sa, sb;
  logic [XLEN-1:0] ub, a_q, abs_a, abs_b, quo, rem, res_hi, res_lo;
  logic [2*XLEN:0] acc, acc_nx;
  logic [XLEN:0] msum, shifted, diff;
  logic [2*XLEN-1:0] prod, prod_c;
  assign sa = ~op[0] & a[XLEN-1];
  assign sb = ~op[0] & b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = busy && cnt == CW'(XLEN - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = RUN;
    else if (last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    msum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, ub} : '0);
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = shifted - {1'b0, ub};
    acc_nx = is_div ? {diff[XLEN] ? shifted : diff, acc[XLEN-2:0], ~diff[XLEN]}
                    : {1'b0, msum, acc[XLEN-1:1]};
    prod = acc_nx[2*XLEN-1:0];
    prod_c = neg_q ? -prod : prod;
    quo = acc_nx[XLEN-1:0];
    rem = acc_nx[2*XLEN-1:XLEN];
    res_lo = is_div ? (div0 ? '1 : (neg_q ? -quo : quo)) : prod_c[XLEN-1:0];
    res_hi = is_div ? (div0 ? a_q : (neg_r ? -rem : rem)) : prod_c[2*XLEN-1:XLEN];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ub <= '0;
      a_q <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        is_div <= op[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        div0 <= op[1] && b == '0;
        a_q <= a;
        ub <= op[1] ? abs_b : abs_a;
        acc <= {{(XLEN+1){1'b0}}, op[1] ? abs_a : abs_b};
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nx;
      end
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
endmodule
